// File: rtl/thread_msg_dispatcher.sv
// Thread-control message dispatcher: buffers FORK/STOP requests and services them against a
// small thread table. Optional statistics counters are built when THRD_DISP_STATS_EN is defined.
module thread_msg_dispatcher #(
    parameter int unsigned      ADDR_W     = 32,
    parameter int unsigned      DATA_W     = 32,
    parameter int unsigned      MSG_W      = 8,
    parameter int unsigned      NTHREADS   = 8,
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter logic [MSG_W-1:0] FORK_THRD  = MSG_W'(8'h10),
    parameter logic [MSG_W-1:0] STOP_THRD  = MSG_W'(8'h11),
    parameter logic [MSG_W-1:0] FORK_DONE  = MSG_W'(8'h12),
    parameter logic [MSG_W-1:0] STOP_DONE  = MSG_W'(8'h13)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clk_oe_i,
    input  logic              cpu_msg_pulse_i,
    input  logic [MSG_W-1:0]  cpu_msg_in_i,
    input  logic [ADDR_W-1:0] addr_in_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              disp_online_o,
    output logic [MSG_W-1:0]  cpu_msg_out_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic [4:0]        thread_cnt_o,
    output logic              ovf_o,
    output logic [15:0]       stat_fork_o,
    output logic [15:0]       stat_stop_o,
    output logic [15:0]       stat_fail_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned IdxW = $clog2(NTHREADS);
    localparam int unsigned EntW = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [NTHREADS-1:0] valid_q, valid_d;
    logic                tbl_we;

    logic                wk_stop_q;
    logic [ADDR_W-1:0]   wk_addr_q;
    logic [DATA_W-1:0]   wk_data_q;

    logic [EntW-1:0]     fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_q, rd_q;
    logic [CntW-1:0]     count_q, count_d;
    logic                ovf_q, disp_online_q;

    logic [ADDR_W-1:0]   tbl_addr_q [NTHREADS];
    logic [DATA_W-1:0]   tbl_data_q [NTHREADS];

    logic req_fork, req_stop, is_req, fifo_full, pop, push, drop, hit;

    assign req_fork  = cpu_msg_pulse_i && (cpu_msg_in_i == FORK_THRD);
    assign req_stop  = cpu_msg_pulse_i && (cpu_msg_in_i == STOP_THRD);
    assign is_req    = req_fork || req_stop;
    assign fifo_full = (count_q == CntW'(FIFO_DEPTH));
    // Pop decision uses the count at cycle start, so a push into an empty FIFO waits a cycle.
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign push      = is_req && (!fifo_full || pop);
    assign drop      = is_req && fifo_full && !pop;
    assign count_d   = count_q + CntW'(push) - CntW'(pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q          <= '0;
            rd_q          <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            disp_online_q <= 1'b0;
            wk_stop_q     <= 1'b0;
            wk_addr_q     <= '0;
            wk_data_q     <= '0;
        end else if (clk_oe_i) begin
            if (push) wr_q <= wr_q + PtrW'(1);
            if (pop) begin
                rd_q <= rd_q + PtrW'(1);
                {wk_stop_q, wk_addr_q, wk_data_q} <= fifo_q[rd_q];
            end
            if (drop) ovf_q <= 1'b1;
            count_q       <= count_d;
            disp_online_q <= (count_d != CntW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (clk_oe_i && push) fifo_q[wr_q] <= {req_stop, addr_in_i, data_in_i};
        if (clk_oe_i && tbl_we) begin
            tbl_addr_q[idx_q] <= wk_addr_q;
            tbl_data_q[idx_q] <= wk_data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            result_q <= '0;
            valid_q  <= '0;
        end else if (clk_oe_i) begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    // FORK looks for a free slot, STOP for a live slot holding the same context pointer.
    assign hit = wk_stop_q ? (valid_q[idx_q] && (tbl_data_q[idx_q] == wk_data_q))
                           : !valid_q[idx_q];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        valid_d  = valid_q;
        tbl_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StScan;
                    idx_d   = '0;
                end
            end
            StScan: begin
                if (hit) begin
                    result_d       = DATA_W'(idx_q) + DATA_W'(1);
                    valid_d[idx_q] = !wk_stop_q;
                    tbl_we         = !wk_stop_q;
                    state_d        = StResp;
                end else if (idx_q == IdxW'(NTHREADS - 1)) begin
                    result_d = '0;
                    state_d  = StResp;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        thread_cnt_o = '0;
        for (int i = 0; i < int'(NTHREADS); i++) begin
            thread_cnt_o = thread_cnt_o + 5'(valid_q[i]);
        end
    end

    assign cpu_msg_out_o = (state_q != StResp) ? '0 : (wk_stop_q ? STOP_DONE : FORK_DONE);
    assign data_out_o    = (state_q == StResp) ? result_q : '0;
    assign disp_online_o = disp_online_q;
    assign ovf_o         = ovf_q;

`ifdef THRD_DISP_STATS_EN
    logic [15:0] stat_fork_q, stat_stop_q, stat_fail_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_fork_q <= '0;
            stat_stop_q <= '0;
            stat_fail_q <= '0;
        end else if (clk_oe_i && (state_q == StResp)) begin
            if (result_q == '0) begin
                if (stat_fail_q != 16'hFFFF) stat_fail_q <= stat_fail_q + 16'd1;
            end else if (wk_stop_q) begin
                if (stat_stop_q != 16'hFFFF) stat_stop_q <= stat_stop_q + 16'd1;
            end else begin
                if (stat_fork_q != 16'hFFFF) stat_fork_q <= stat_fork_q + 16'd1;
            end
        end
    end

    assign stat_fork_o = stat_fork_q;
    assign stat_stop_o = stat_stop_q;
    assign stat_fail_o = stat_fail_q;
`else
    assign stat_fork_o = '0;
    assign stat_stop_o = '0;
    assign stat_fail_o = '0;
`endif

endmodule

// File: tb/tb_thread_msg_dispatcher.sv
// Directed bench for thread_msg_dispatcher: fork/stop servicing, table-full and miss cases,
// FIFO overflow, clk_oe gating, reset during a scan and the optional statistics counters.
module tb_thread_msg_dispatcher;

    localparam logic [7:0] FORK_THRD = 8'h10;
    localparam logic [7:0] STOP_THRD = 8'h11;
    localparam logic [7:0] FORK_DONE = 8'h12;
    localparam logic [7:0] STOP_DONE = 8'h13;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        clk_oe = 1'b1;
    logic        pulse = 1'b0;
    logic [7:0]  msg_in = '0;
    logic [31:0] addr_in = '0;
    logic [31:0] data_in = '0;

    logic        disp_online, ovf;
    logic [7:0]  cpu_msg_out;
    logic [31:0] data_out;
    logic [4:0]  thread_cnt;
    logic [15:0] stat_fork, stat_stop, stat_fail;

    int tests = 0;
    int fails = 0;

    thread_msg_dispatcher dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .clk_oe_i       (clk_oe),
        .cpu_msg_pulse_i(pulse),
        .cpu_msg_in_i   (msg_in),
        .addr_in_i      (addr_in),
        .data_in_i      (data_in),
        .disp_online_o  (disp_online),
        .cpu_msg_out_o  (cpu_msg_out),
        .data_out_o     (data_out),
        .thread_cnt_o   (thread_cnt),
        .ovf_o          (ovf),
        .stat_fork_o    (stat_fork),
        .stat_stop_o    (stat_stop),
        .stat_fail_o    (stat_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] m, input logic [31:0] a, input logic [31:0] d);
        pulse   = 1'b1;
        msg_in  = m;
        addr_in = a;
        data_in = d;
        tick();
        pulse  = 1'b0;
        msg_in = '0;
    endtask

    // Latency counts enabled edges from the request pulse edge to the response cycle.
    task automatic wait_resp(input bit toggle, output logic [7:0] m, output logic [31:0] d,
                             output int lat);
        lat = 1;
        m   = '0;
        d   = '0;
        for (int i = 0; i < 200; i++) begin
            if (cpu_msg_out !== 8'h00) begin
                m = cpu_msg_out;
                d = data_out;
                return;
            end
            if (toggle) clk_oe = ~clk_oe;
            if (clk_oe) lat++;
            tick();
        end
        lat = -1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    logic [7:0]  rm;
    logic [31:0] rd;
    int          lat;
    int          extra;
    logic [7:0]  exp_m [5];
    logic [31:0] exp_d [5];

    initial begin
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_online", 32'(disp_online), 0);
        chk("rst_msg", 32'(cpu_msg_out), 0);
        chk("rst_data", data_out, 0);
        chk("rst_cnt", 32'(thread_cnt), 0);
        chk("rst_ovf", 32'(ovf), 0);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        chk("online_after_rst", 32'(disp_online), 1);

        // First fork lands in slot 0 -> handle 1 after 3 enabled cycles.
        send(FORK_THRD, 32'h100, 32'h2000);
        wait_resp(1'b0, rm, rd, lat);
        chk("f1_msg", 32'(rm), 32'(FORK_DONE));
        chk("f1_data", rd, 1);
        chk("f1_lat", 32'(lat), 3);
        chk("f1_cnt", 32'(thread_cnt), 1);
        tick();
        chk("f1_msg_clr", 32'(cpu_msg_out), 0);
        chk("f1_data_clr", data_out, 0);

        send(FORK_THRD, 32'h200, 32'h3000);
        wait_resp(1'b0, rm, rd, lat);
        chk("f2_data", rd, 2);
        chk("f2_lat", 32'(lat), 4);
        tick();

        send(STOP_THRD, 32'h0, 32'h3000);
        wait_resp(1'b0, rm, rd, lat);
        chk("s1_msg", 32'(rm), 32'(STOP_DONE));
        chk("s1_data", rd, 2);
        chk("s1_lat", 32'(lat), 4);
        chk("s1_cnt", 32'(thread_cnt), 1);
        tick();

        send(STOP_THRD, 32'h0, 32'h9999);
        wait_resp(1'b0, rm, rd, lat);
        chk("s2_msg", 32'(rm), 32'(STOP_DONE));
        chk("s2_data", rd, 0);
        chk("s2_lat", 32'(lat), 10);
        chk("s2_cnt", 32'(thread_cnt), 1);
        tick();

        // Ignored code must not produce a response.
        send(8'h55, 32'h0, 32'h1);
        extra = 0;
        repeat (12) begin
            if (cpu_msg_out !== 8'h00) extra++;
            tick();
        end
        chk("ignored_code", 32'(extra), 0);

        // Fill remaining seven slots; the eighth fork finds the table full.
        for (int i = 0; i < 8; i++) begin
            send(FORK_THRD, 32'h400 + 32'(i), 32'h5000 + 32'(i));
            wait_resp(1'b0, rm, rd, lat);
            chk("fill_msg", 32'(rm), 32'(FORK_DONE));
            chk("fill_data", rd, (i < 7) ? 32'(i + 2) : 32'h0);
            tick();
        end
        chk("full_lat", 32'(lat), 10);
        chk("full_cnt", 32'(thread_cnt), 8);
        chk("no_ovf", 32'(ovf), 0);
`ifdef THRD_DISP_STATS_EN
        chk("stat_fork", 32'(stat_fork), 9);
        chk("stat_stop", 32'(stat_stop), 1);
        chk("stat_fail", 32'(stat_fail), 2);
`else
        chk("stat_fork", 32'(stat_fork), 0);
        chk("stat_stop", 32'(stat_stop), 0);
        chk("stat_fail", 32'(stat_fail), 0);
`endif

        // Overflow: a slow STOP miss holds the FSM while five forks arrive back to back.
        do_reset();
        send(STOP_THRD, 32'h0, 32'hDEAD);
        for (int i = 1; i <= 4; i++) send(FORK_THRD, 32'h700 + 32'(i), 32'hA0 + 32'(i));
        chk("ovf_online_low", 32'(disp_online), 0);
        chk("ovf_before", 32'(ovf), 0);
        send(FORK_THRD, 32'h705, 32'hA5);
        chk("ovf_set", 32'(ovf), 1);
        exp_m[0] = STOP_DONE;
        exp_d[0] = 32'h0;
        for (int i = 1; i < 5; i++) begin
            exp_m[i] = FORK_DONE;
            exp_d[i] = 32'(i);
        end
        for (int i = 0; i < 5; i++) begin
            wait_resp(1'b0, rm, rd, lat);
            chk("ovf_resp_msg", 32'(rm), 32'(exp_m[i]));
            chk("ovf_resp_data", rd, exp_d[i]);
            tick();
        end
        extra = 0;
        repeat (30) begin
            if (cpu_msg_out !== 8'h00) extra++;
            tick();
        end
        chk("ovf_no_sixth", 32'(extra), 0);
        chk("ovf_cnt", 32'(thread_cnt), 4);
        chk("ovf_online_back", 32'(disp_online), 1);

        // clk_oe toggling: latency measured in enabled cycles only.
        do_reset();
        chk("rst_clears_ovf", 32'(ovf), 0);
        send(FORK_THRD, 32'h100, 32'h2000);
        wait_resp(1'b1, rm, rd, lat);
        chk("oe_msg", 32'(rm), 32'(FORK_DONE));
        chk("oe_data", rd, 1);
        chk("oe_lat", 32'(lat), 3);
        clk_oe = 1'b0;
        tick();
        chk("oe_hold_msg", 32'(cpu_msg_out), 32'(FORK_DONE));
        chk("oe_hold_data", data_out, 1);
        clk_oe = 1'b1;
        tick();
        chk("oe_release_msg", 32'(cpu_msg_out), 0);
        chk("oe_cnt", 32'(thread_cnt), 1);

        // Reset in the middle of a scan aborts without a response.
        send(FORK_THRD, 32'h110, 32'h2100);
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        chk("midrst_cnt", 32'(thread_cnt), 0);
        chk("midrst_online", 32'(disp_online), 0);
        chk("midrst_msg", 32'(cpu_msg_out), 0);
        tick();
        rst_ni = 1'b1;
        extra = 0;
        repeat (15) begin
            if (cpu_msg_out !== 8'h00) extra++;
            tick();
        end
        chk("midrst_no_resp", 32'(extra), 0);
        chk("midrst_stat_fork", 32'(stat_fork), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
